div_vl: RTL and testbench
=========================

DIV_VL -- requirements
Module: div_vl

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  reset; synchronous and active-high.
REQ-004 Port: start  input  1  one-cycle request; sampled only when busy=0.
REQ-005 Port: dvdnd  input  32  dividend; sampled at the same edge as start.
REQ-006 Port: dvsor  input  32  divisor; sampled at the same edge as start.
REQ-007 Port: quot  output  32  quotient, registered.
REQ-008 Port: rmdr  output  32  remainder, registered.
REQ-009 Port: valid  output  1  one-cycle pulse; quot, rmdr and div_zero are valid in that cycle.
REQ-010 Port: busy  output  1  high from the cycle after an accepted start through the valid cycle.
REQ-011 Port: div_zero  output  1  high with valid when dvsor was 0.

Function
REQ-012 States SHALL be IDLE, LOAD, ITER, FIX and DONE.
REQ-013 Transitions: IDLE->LOAD on an accepted start; LOAD->DONE on a trivial case (REQ-014); otherwise LOAD->ITER; ITER->FIX when the iteration count reaches 0; FIX->DONE; DONE->IDLE.
REQ-014 LOAD SHALL register the operand magnitudes and lz, the leading-zero count of the dividend magnitude. Trivial cases are: divisor=0; dividend=0; |dividend|<|divisor|.
REQ-015 ITER SHALL perform one restoring shift-subtract step per cycle for N=32-lz cycles, skipping the leading-zero bits of the dividend (variable latency).
REQ-016 valid SHALL assert 2 cycles after the start edge in trivial cases, and N+3 cycles after it otherwise.
REQ-017 Divide by zero: quot=0xFFFFFFFF, rmdr=dvdnd, div_zero=1.
REQ-018 Dividend 0: quot=0, rmdr=0.
REQ-019 |dividend|<|divisor|: quot=0, rmdr=dvdnd.
REQ-020 Results SHALL hold until the next accepted start, then clear to 0 in LOAD.
REQ-021 start while busy=1 SHALL be ignored; start in the valid (DONE) cycle SHALL be accepted, giving back-to-back operation.
REQ-022 Invariant: dvdnd = quot*dvsor + rmdr, with |rmdr| < |dvsor| whenever dvsor != 0.

Reset
REQ-023 reset=1 SHALL force IDLE and quot=0, rmdr=0, valid=0, busy=0, div_zero=0 at the next edge, in any state.
REQ-024 reset in mid-operation SHALL discard the operation with no valid pulse.
REQ-025 reset has priority over a simultaneous start.

Configuration
REQ-026 Macro DIV_VL_SIGNED_EN defined: operands are two's complement.
- Quotient truncates toward zero; rmdr takes the sign of the dividend.
- FIX negates the results as required.
- 0x80000000/0xFFFFFFFF gives quot=0x80000000, rmdr=0.
REQ-027 Macro DIV_VL_SIGNED_EN undefined: operands are unsigned; FIX is a pass-through cycle, so latency is unchanged.

Structure
REQ-028 Package div_vl_pkg SHALL hold WIDTH, the state encoding constants, and the all-ones quotient constant.
REQ-029 Sub-module lzc32 (32-bit leading-zero counter, combinational, 6-bit output, 32 for input 0) SHALL be instantiated once.

Verification
REQ-030 Unsigned 100/7 -> quot=14, rmdr=2, valid 10 cycles after start (N=7).
REQ-031 5/0 -> quot=0xFFFFFFFF, rmdr=5, div_zero=1, valid 2 cycles after start.
REQ-032 0xFFFFFFF9/2 -> with DIV_VL_SIGNED_EN: quot=0xFFFFFFFD, rmdr=0xFFFFFFFF; without it: quot=0x7FFFFFFC, rmdr=1.
REQ-033 Unsigned 0xFFFFFFFF/1 -> quot=0xFFFFFFFF, rmdr=0, valid 35 cycles after start.
REQ-034 reset asserted in ITER of 1000/3 -> all outputs 0 next cycle, no valid pulse; a following 9/3 -> quot=3, rmdr=0.
REQ-035 start during busy ignored; start in the valid cycle of 100/7 with 8/2 -> second valid gives quot=4, rmdr=0.

Source files
------------

// File: rtl/div_vl_pkg.sv
// Shared definitions for the variable-latency divider: data width, FSM state
// encoding and the all-ones quotient reported on divide-by-zero.
package div_vl_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] QUOT_ONES = '1;

endpackage

// File: rtl/div_vl_lzc32.sv
// 32-bit leading-zero counter, purely combinational; an all-zero input gives 32.
module lzc32 (
    input  logic [31:0] value,
    output logic [5:0]  count
);

    // Ascending scan: the highest set bit is the last one to write count.
    always_comb begin
        count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                count = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/div_vl.sv
// Variable-latency restoring divider that skips the dividend's leading zeros.
// Define DIV_VL_SIGNED_EN for two's-complement operands; otherwise unsigned.
module div_vl #(
    parameter int WIDTH = div_vl_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dvdnd,
    input  logic [WIDTH-1:0] dvsor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rmdr,
    output logic             valid,
    output logic             busy,
    output logic             div_zero
);

    import div_vl_pkg::*;

    state_t      state;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] mag_b;
    logic [31:0] qa;
    logic [31:0] rem;
    logic [5:0]  cnt;
    logic [5:0]  lz;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] rem_sh;
    logic        take;

`ifdef DIV_VL_SIGNED_EN
    logic neg_q;
    logic neg_r;
    assign sign_a = op_a[31];
    assign sign_b = op_b[31];
`else
    assign sign_a = 1'b0;
    assign sign_b = 1'b0;
`endif

    assign abs_a = sign_a ? (32'd0 - op_a) : op_a;
    assign abs_b = sign_b ? (32'd0 - op_b) : op_b;

    lzc32 u_lzc (
        .value (abs_a),
        .count (lz)
    );

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_sh = {rem, qa[31]};
    assign take   = rem_sh >= {1'b0, mag_b};

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            quot     <= '0;
            rmdr     <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                // DONE shares IDLE's accept path so a start in the valid cycle chains.
                IDLE, DONE: begin
                    if (start) begin
                        op_a     <= dvdnd;
                        op_b     <= dvsor;
                        quot     <= '0;
                        rmdr     <= '0;
                        div_zero <= 1'b0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    mag_b <= abs_b;
                    qa    <= abs_a << lz;
                    rem   <= '0;
                    cnt   <= 6'd32 - lz;
`ifdef DIV_VL_SIGNED_EN
                    neg_q <= sign_a ^ sign_b;
                    neg_r <= sign_a;
`endif
                    if (op_b == 32'd0) begin
                        quot     <= QUOT_ONES;
                        rmdr     <= op_a;
                        div_zero <= 1'b1;
                        valid    <= 1'b1;
                        state    <= DONE;
                    end else if (abs_a == 32'd0) begin
                        valid <= 1'b1;
                        state <= DONE;
                    end else if (abs_a < abs_b) begin
                        rmdr  <= op_a;
                        valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    rem <= take ? 32'(rem_sh - {1'b0, mag_b}) : rem_sh[31:0];
                    qa  <= {qa[30:0], take};
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        state <= FIX;
                    end
                end
                FIX: begin
`ifdef DIV_VL_SIGNED_EN
                    quot <= neg_q ? (32'd0 - qa) : qa;
                    rmdr <= neg_r ? (32'd0 - rem) : rem;
`else
                    quot <= qa;
                    rmdr <= rem;
`endif
                    valid <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_vl.sv
// Self-checking bench for div_vl; expectations come from a behavioural model
// pushed into a scoreboard queue. Honours DIV_VL_SIGNED_EN like the design.
module tb_div_vl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dvdnd;
    logic [31:0] dvsor;
    logic [31:0] quot;
    logic [31:0] rmdr;
    logic        valid;
    logic        busy;
    logic        div_zero;

    div_vl dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .dvdnd    (dvdnd),
        .dvsor    (dvsor),
        .quot     (quot),
        .rmdr     (rmdr),
        .valid    (valid),
        .busy     (busy),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference result and latency (cycles from the start cycle to the valid cycle).
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] ma;
        logic [31:0] mb;
        int          n;
        e.a  = a;
        e.b  = b;
        e.q  = '0;
        e.r  = '0;
        e.dz = 1'b0;
`ifdef DIV_VL_SIGNED_EN
        ma = a[31] ? (32'd0 - a) : a;
        mb = b[31] ? (32'd0 - b) : b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else if (b != 32'd0) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end
`else
        ma = a;
        mb = b;
        if (b != 32'd0) begin
            e.q = a / b;
            e.r = a % b;
        end
`endif
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (ma[i]) n = i + 1;
        end
        if (b == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 2;
        end else if (a == 32'd0 || ma < mb) begin
            e.lat = 2;
        end else begin
            e.lat = n + 3;
        end
        return e;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Drives a one-cycle start and records the expected outcome.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        dvdnd = a;
        dvsor = b;
        start = 1'b1;
        sb.push_back(model(a, b));
        tick;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int from, output int cycles);
        cycles = from;
        while (valid !== 1'b1 && cycles < 60) begin
            tick;
            cycles++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        dvdnd = '0;
        dvsor = '0;
        tick;
        tick;
        total++; if (quot !== 32'd0) begin bad++; $display("[TB] FAIL reset_quot got=%h want=0", quot); end
        total++; if (rmdr !== 32'd0) begin bad++; $display("[TB] FAIL reset_rmdr got=%h want=0", rmdr); end
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("[TB] FAIL reset_div_zero got=%b want=0", div_zero); end
        dvdnd = 32'd100;
        dvsor = 32'd7;
        start = 1'b1;
        tick;
        reset = 1'b0;
        start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_priority busy got=%b want=0", busy); end
        tick;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_priority_after busy got=%b want=0", busy); end
    endtask

    task automatic test_ops;
        logic [31:0] va[$];
        logic [31:0] vb[$];
        exp_t        e;
        int          cyc;
        va = '{32'd100, 32'd5, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd0, 32'd3, 32'h8000_0000, 32'd7};
        vb = '{32'd7,   32'd0, 32'd2,         32'd1,         32'd9, 32'd10, 32'hFFFF_FFFF, 32'd7};
        for (int i = 0; i < 6; i++) begin
            va.push_back($urandom);
            vb.push_back($urandom >> $urandom_range(4, 28));
        end
        foreach (va[i]) begin
            launch(va[i], vb[i]);
            wait_valid(1, cyc);
            if (valid !== 1'b1) begin
                total++; bad++;
                $display("[TB] FAIL ops_timeout %h/%h no valid after %0d cycles", va[i], vb[i], cyc);
                sb.delete();
            end else begin
                e = sb.pop_front();
                total++; if (quot !== e.q) begin bad++; $display("[TB] FAIL ops_quot %h/%h got=%h want=%h", e.a, e.b, quot, e.q); end
                total++; if (rmdr !== e.r) begin bad++; $display("[TB] FAIL ops_rmdr %h/%h got=%h want=%h", e.a, e.b, rmdr, e.r); end
                total++; if (div_zero !== e.dz) begin bad++; $display("[TB] FAIL ops_div_zero %h/%h got=%b want=%b", e.a, e.b, div_zero, e.dz); end
                total++; if (cyc != e.lat) begin bad++; $display("[TB] FAIL ops_latency %h/%h got=%0d want=%0d", e.a, e.b, cyc, e.lat); end
                total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL ops_busy_in_valid %h/%h got=%b want=1", e.a, e.b, busy); end
                tick;
                total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL ops_valid_pulse %h/%h got=%b want=0", e.a, e.b, valid); end
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   cyc;
        launch(32'd100, 32'd7);
        wait_valid(1, cyc);
        if (valid !== 1'b1) begin
            total++; bad++;
            $display("[TB] FAIL b2b_first_timeout no valid after %0d cycles", cyc);
            sb.delete();
        end else begin
            e = sb.pop_front();
            total++; if (quot !== e.q) begin bad++; $display("[TB] FAIL b2b_first_quot got=%h want=%h", quot, e.q); end
            total++; if (rmdr !== e.r) begin bad++; $display("[TB] FAIL b2b_first_rmdr got=%h want=%h", rmdr, e.r); end
            launch(32'd8, 32'd2);
            wait_valid(1, cyc);
            if (valid !== 1'b1) begin
                total++; bad++;
                $display("[TB] FAIL b2b_second_timeout no valid after %0d cycles", cyc);
                sb.delete();
            end else begin
                e = sb.pop_front();
                total++; if (quot !== e.q) begin bad++; $display("[TB] FAIL b2b_second_quot got=%h want=%h", quot, e.q); end
                total++; if (rmdr !== e.r) begin bad++; $display("[TB] FAIL b2b_second_rmdr got=%h want=%h", rmdr, e.r); end
                total++; if (cyc != e.lat) begin bad++; $display("[TB] FAIL b2b_second_latency got=%0d want=%0d", cyc, e.lat); end
            end
        end
        tick;
    endtask

    task automatic test_busy_ignore;
        exp_t e;
        int   cyc;
        bit   seen;
        launch(32'd100, 32'd7);
        tick;
        tick;
        dvdnd = 32'd1;
        dvsor = 32'd1;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_valid(4, cyc);
        if (valid !== 1'b1) begin
            total++; bad++;
            $display("[TB] FAIL busy_timeout no valid after %0d cycles", cyc);
            sb.delete();
        end else begin
            e = sb.pop_front();
            total++; if (quot !== e.q) begin bad++; $display("[TB] FAIL busy_quot got=%h want=%h", quot, e.q); end
            total++; if (rmdr !== e.r) begin bad++; $display("[TB] FAIL busy_rmdr got=%h want=%h", rmdr, e.r); end
            total++; if (cyc != e.lat) begin bad++; $display("[TB] FAIL busy_latency got=%0d want=%0d", cyc, e.lat); end
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick;
                if (valid === 1'b1) seen = 1'b1;
            end
            total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL busy_extra_valid got=%b want=0", seen); end
            total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_idle got=%b want=0", busy); end
            total++; if (quot !== e.q) begin bad++; $display("[TB] FAIL busy_hold_quot got=%h want=%h", quot, e.q); end
        end
    endtask

    task automatic test_mid_reset;
        exp_t e;
        int   cyc;
        bit   seen;
        launch(32'd1000, 32'd3);
        sb.delete();
        tick;
        tick;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy got=%b want=1", busy); end
        total++; if (quot !== 32'd0) begin bad++; $display("[TB] FAIL mid_cleared_quot got=%h want=0", quot); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        total++; if (quot !== 32'd0) begin bad++; $display("[TB] FAIL mid_reset_quot got=%h want=0", quot); end
        total++; if (rmdr !== 32'd0) begin bad++; $display("[TB] FAIL mid_reset_rmdr got=%h want=0", rmdr); end
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_valid got=%b want=0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_busy got=%b want=0", busy); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_div_zero got=%b want=0", div_zero); end
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick;
            if (valid === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_stray_valid got=%b want=0", seen); end
        launch(32'd9, 32'd3);
        wait_valid(1, cyc);
        if (valid !== 1'b1) begin
            total++; bad++;
            $display("[TB] FAIL mid_after_timeout no valid after %0d cycles", cyc);
            sb.delete();
        end else begin
            e = sb.pop_front();
            total++; if (quot !== e.q) begin bad++; $display("[TB] FAIL mid_after_quot got=%h want=%h", quot, e.q); end
            total++; if (rmdr !== e.r) begin bad++; $display("[TB] FAIL mid_after_rmdr got=%h want=%h", rmdr, e.r); end
            total++; if (cyc != e.lat) begin bad++; $display("[TB] FAIL mid_after_latency got=%0d want=%0d", cyc, e.lat); end
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_ops;
        test_back_to_back;
        test_busy_ignore;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
